// File: rtl/rv32i_gen_pkg.sv
// Shared definitions for the RV32I instruction generator: class order,
// match/mask encoding tables, LFSR polynomial and small helpers.
package rv32i_gen_pkg;

  localparam int unsigned NUM_CLASSES = 37;
  localparam int unsigned CLASS_W     = 6;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned REP_W       = 16;

  localparam logic [XLEN-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [CLASS_W-1:0] {
    CL_LUI,  CL_AUIPC, CL_JAL,  CL_JALR, CL_BEQ,  CL_BNE,  CL_BLT,  CL_BGE,
    CL_BLTU, CL_BGEU,  CL_LB,   CL_LH,   CL_LW,   CL_LBU,  CL_LHU,  CL_SB,
    CL_SH,   CL_SW,    CL_ADDI, CL_SLTI, CL_SLTIU, CL_XORI, CL_ORI, CL_ANDI,
    CL_SLLI, CL_SRLI,  CL_SRAI, CL_ADD,  CL_SUB,  CL_SLL,  CL_SLT,  CL_SLTU,
    CL_XOR,  CL_SRL,   CL_SRA,  CL_OR,   CL_AND
  } insn_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } gen_state_e;

  // Standard RISC-V match/mask pairs, indexed by insn_class_e
  localparam logic [XLEN-1:0] MATCH [NUM_CLASSES] = '{
    32'h0000_0037, 32'h0000_0017, 32'h0000_006f, 32'h0000_0067,
    32'h0000_0063, 32'h0000_1063, 32'h0000_4063, 32'h0000_5063,
    32'h0000_6063, 32'h0000_7063,
    32'h0000_0003, 32'h0000_1003, 32'h0000_2003, 32'h0000_4003, 32'h0000_5003,
    32'h0000_0023, 32'h0000_1023, 32'h0000_2023,
    32'h0000_0013, 32'h0000_2013, 32'h0000_3013, 32'h0000_4013,
    32'h0000_6013, 32'h0000_7013,
    32'h0000_1013, 32'h0000_5013, 32'h4000_5013,
    32'h0000_0033, 32'h4000_0033, 32'h0000_1033, 32'h0000_2033,
    32'h0000_3033, 32'h0000_4033, 32'h0000_5033, 32'h4000_5033,
    32'h0000_6033, 32'h0000_7033
  };

  localparam logic [XLEN-1:0] MASK [NUM_CLASSES] = '{
    32'h0000_007f, 32'h0000_007f, 32'h0000_007f, 32'h0000_707f,
    32'h0000_707f, 32'h0000_707f, 32'h0000_707f, 32'h0000_707f,
    32'h0000_707f, 32'h0000_707f,
    32'h0000_707f, 32'h0000_707f, 32'h0000_707f, 32'h0000_707f, 32'h0000_707f,
    32'h0000_707f, 32'h0000_707f, 32'h0000_707f,
    32'h0000_707f, 32'h0000_707f, 32'h0000_707f, 32'h0000_707f,
    32'h0000_707f, 32'h0000_707f,
    32'hfe00_707f, 32'hfe00_707f, 32'hfe00_707f,
    32'hfe00_707f, 32'hfe00_707f, 32'hfe00_707f, 32'hfe00_707f,
    32'hfe00_707f, 32'hfe00_707f, 32'hfe00_707f, 32'hfe00_707f,
    32'hfe00_707f, 32'hfe00_707f
  };

  function automatic logic [XLEN-1:0] lfsr_next(input logic [XLEN-1:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1
  function automatic logic [XLEN-1:0] lfsr_seed(input logic [XLEN-1:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [XLEN-1:0] encode(input logic [CLASS_W-1:0] cls,
                                             input logic [XLEN-1:0]    l);
    if (cls < CLASS_W'(NUM_CLASSES)) begin
      return (l & ~MASK[cls]) | MATCH[cls];
    end
    return '0;
  endfunction

endpackage

// File: rtl/rv32i_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous load and step enable.
module rv32i_lfsr32
  import rv32i_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_adv,
  output logic [31:0] o_value
);

  logic [31:0] r_lfsr;

  // Load has priority over advance; both are mutually exclusive in practice
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= lfsr_seed(SEED);
    end else if (i_load) begin
      r_lfsr <= lfsr_seed(i_load_val);
    end else if (i_adv) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/rv32i_insn_gen.sv
// Sweeps all 37 RV32I classes, emitting REPEAT LFSR-randomised but legal
// instruction words per class over a valid/ready handshake.
module rv32i_insn_gen
  import rv32i_gen_pkg::*;
#(
  parameter int unsigned REPEAT = 4,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed,
  output logic [31:0] insn,
  output logic [5:0]  insn_class,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic        done
);

  localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(REPEAT - 1);
  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(CL_AND);
  localparam logic [CLASS_W-1:0] CLASS_END  = CLASS_W'(NUM_CLASSES);

  gen_state_e         r_state;
  gen_state_e         w_state_nxt;
  logic [CLASS_W-1:0] r_class;
  logic [CLASS_W-1:0] w_class_nxt;
  logic [REP_W-1:0]   r_rep;
  logic [REP_W-1:0]   w_rep_nxt;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               w_hs;
  logic               w_load;
  logic               w_adv;
  logic [31:0]        w_lfsr;

  rv32i_lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (seed),
    .i_adv      (w_adv),
    .o_value    (w_lfsr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_class <= '0;
      r_rep   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_class <= w_class_nxt;
      r_rep   <= w_rep_nxt;
      r_valid <= (w_state_nxt == ST_RUN) && (w_class_nxt < CLASS_END);
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state, counter and LFSR control
  always_comb begin
    w_state_nxt = r_state;
    w_class_nxt = r_class;
    w_rep_nxt   = r_rep;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_hs        = r_valid && ready;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_class_nxt = '0;
          w_rep_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_class >= CLASS_END) begin
          // Unreachable class index: retire the sweep rather than emit garbage
          w_state_nxt = ST_DONE;
        end else if (w_hs) begin
          w_adv = 1'b1;
          if (r_rep == REP_LAST) begin
            w_rep_nxt = '0;
            if (r_class == LAST_CLASS) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_class_nxt = r_class + CLASS_W'(1);
            end
          end else begin
            w_rep_nxt = r_rep + REP_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign insn       = r_valid ? encode(r_class, w_lfsr) : '0;
  assign insn_class = r_class;
  assign valid      = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_rv32i_insn_gen.sv
// Directed scoreboard bench for rv32i_insn_gen: two instances (REPEAT=4 and
// REPEAT=1) checked against an independent LFSR/encoding model.
module tb_rv32i_insn_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        ready_a, ready_b;
  logic [31:0] seed_a, seed_b;
  logic [31:0] insn_a, insn_b;
  logic [5:0]  cls_a, cls_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [37:0] sb_q [$];

  localparam logic [31:0] TB_MATCH [37] = '{
    32'h37, 32'h17, 32'h6f, 32'h67, 32'h63, 32'h1063, 32'h4063, 32'h5063,
    32'h6063, 32'h7063, 32'h03, 32'h1003, 32'h2003, 32'h4003, 32'h5003,
    32'h23, 32'h1023, 32'h2023, 32'h13, 32'h2013, 32'h3013, 32'h4013,
    32'h6013, 32'h7013, 32'h1013, 32'h5013, 32'h40005013, 32'h33,
    32'h40000033, 32'h1033, 32'h2033, 32'h3033, 32'h4033, 32'h5033,
    32'h40005033, 32'h6033, 32'h7033
  };
  localparam logic [31:0] TB_MASK [37] = '{
    32'h7f, 32'h7f, 32'h7f, 32'h707f, 32'h707f, 32'h707f, 32'h707f, 32'h707f,
    32'h707f, 32'h707f, 32'h707f, 32'h707f, 32'h707f, 32'h707f, 32'h707f,
    32'h707f, 32'h707f, 32'h707f, 32'h707f, 32'h707f, 32'h707f, 32'h707f,
    32'h707f, 32'h707f, 32'hfe00707f, 32'hfe00707f, 32'hfe00707f, 32'hfe00707f,
    32'hfe00707f, 32'hfe00707f, 32'hfe00707f, 32'hfe00707f, 32'hfe00707f,
    32'hfe00707f, 32'hfe00707f, 32'hfe00707f, 32'hfe00707f
  };

  rv32i_insn_gen #(.REPEAT(4), .SEED(32'h1)) u_dut_a (
    .clock (clock), .reset (reset), .start (start_a), .seed (seed_a),
    .insn (insn_a), .insn_class (cls_a), .valid (valid_a), .ready (ready_a),
    .busy (busy_a), .done (done_a)
  );

  rv32i_insn_gen #(.REPEAT(1), .SEED(32'h1)) u_dut_b (
    .clock (clock), .reset (reset), .start (start_b), .seed (seed_b),
    .insn (insn_b), .insn_class (cls_b), .valid (valid_b), .ready (ready_b),
    .busy (busy_b), .done (done_b)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] tb_next(input logic [31:0] l);
    logic [31:0] t;
    t = {1'b0, l[31:1]};
    if (l[0]) t = t ^ 32'h8020_0003;
    return t;
  endfunction

  function automatic logic [31:0] tb_enc(input int c, input logic [31:0] l);
    return (l & ~TB_MASK[c]) | TB_MATCH[c];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input logic [31:0] sd, input int rep);
    logic [31:0] l;
    sb_q.delete();
    l = (sd == 32'h0) ? 32'h1 : sd;
    for (int c = 0; c < 37; c++) begin
      for (int r = 0; r < rep; r++) begin
        sb_q.push_back({6'(c), tb_enc(c, l)});
        l = tb_next(l);
      end
    end
  endtask

  // Coverage-decoder view: exactly one class pattern must hit, and it must be cls
  task automatic decode_check(input logic [31:0] word, input logic [5:0] cls);
    int hits;
    int idx;
    hits = 0;
    idx  = -1;
    for (int k = 0; k < 37; k++) begin
      if ((word & TB_MASK[k]) == TB_MATCH[k]) begin
        hits++;
        idx = k;
      end
    end
    check("decode_hits", 32'(hits), 32'd1);
    check("decode_class", 32'(idx), 32'(cls));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid_a), 32'd0);
    check({tag, "_busy"},  32'(busy_a),  32'd0);
    check({tag, "_done"},  32'(done_a),  32'd0);
    check({tag, "_insn"},  insn_a,       32'd0);
    check({tag, "_class"}, 32'(cls_a),   32'd0);
  endtask

  // Runs one sweep on DUT a; abort_at>0 asserts reset at that handshake
  task automatic run_sweep(input logic [31:0] sd, input int abort_at, input bit poke);
    int          hs;
    int          last;
    bit          aborted;
    bit          saw_done;
    logic [37:0] e;
    fill(sd, 4);
    seed_a  = sd;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a  = 1'b0;
    hs       = 0;
    last     = -1;
    aborted  = 1'b0;
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      start_a = 1'b0;
      if (done_a) begin
        saw_done = 1'b1;
        check("done_latency", 32'(cyc), 32'(last + 1));
        break;
      end
      if (valid_a) begin
        check("busy_in_run", 32'(busy_a), 32'd1);
        if (sb_q.size() == 0) begin
          check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("insn", insn_a, e[31:0]);
          check("insn_class", 32'(cls_a), 32'(e[37:32]));
          decode_check(insn_a, cls_a);
        end
        hs++;
        last = cyc;
        if (hs == abort_at) begin
          reset = 1'b1;
          #1;
          check_reset_outputs("midsweep_reset");
          aborted = 1'b1;
          break;
        end
        if (poke && hs == 20) start_a = 1'b1;
      end
      tick();
    end
    if (!aborted) begin
      check("sweep_done_seen", 32'(saw_done), 32'd1);
      check("handshake_count", 32'(hs), 32'd148);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      check("done_valid_low", 32'(valid_a), 32'd0);
      check("done_busy_low", 32'(busy_a), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] l;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    seed_a  = '0;
    seed_b  = '0;
    repeat (2) tick();
    reset = 1'b0;

    // Idle after reset, no start
    for (int i = 0; i < 10; i++) begin
      tick();
      check_reset_outputs("idle");
      check("idle_valid_b", 32'(valid_b), 32'd0);
    end

    // REPEAT=1: first two words are fixed by seed=1
    seed_b  = 32'h1;
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("first_valid", 32'(valid_b), 32'd1);
    check("first_insn", insn_b, 32'h0000_0037);
    check("first_class", 32'(cls_b), 32'd0);
    tick();
    check("second_insn", insn_b, 32'h8020_0017);
    check("second_class", 32'(cls_b), 32'd1);

    // Backpressure: outputs hold and LFSR does not step
    ready_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(valid_b), 32'd1);
      check("stall_insn", insn_b, 32'h8020_0017);
      check("stall_class", 32'(cls_b), 32'd1);
    end
    ready_b = 1'b1;
    tick();
    l = tb_next(tb_next(32'h1));
    check("post_stall_insn", insn_b, tb_enc(2, l));
    check("post_stall_class", 32'(cls_b), 32'd2);
    for (int i = 0; i < 100; i++) begin
      if (done_b) break;
      tick();
    end
    check("b_done", 32'(done_b), 32'd1);

    // Full sweep with a start pulse injected mid-run
    run_sweep(32'h1, 0, 1'b1);
    repeat (3) tick();
    check("done_sticky", 32'(done_a), 32'd1);

    // Restart from DONE with seed 0 (behaves as seed 1)
    run_sweep(32'h0, 0, 1'b0);

    // Reset mid-sweep, then a fresh run reproduces the sequence
    run_sweep(32'h1, 50, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("post_reset_idle");
    run_sweep(32'h1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
